rv151_rgf_byp: RTL

RV151_RGF_BYP -- requirements
Module: rv151_rgf_byp

---
 rtl/rv151_pkg.sv | 18 +
 rtl/rv151_rgf_byp_if.sv | 34 +++
 rtl/rv151_rgf_clr.sv | 66 ++++++
 rtl/rv151_rgf_byp.sv | 73 +++++++
 4 files changed

// File: rtl/rv151_pkg.sv
// +------------------------------------------------------------------+
// | rv151_pkg : shared types and defaults for the rv151 register file |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rv151_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [0:0] {
    RGF_IDLE  = 1'b0,
    RGF_CLEAR = 1'b1
  } rgf_state_t;

endpackage

`default_nettype wire

// File: rtl/rv151_rgf_byp_if.sv
// +------------------------------------------------------------------+
// | rv151_rgf_byp_if : write/read/clear port bundle of the reg file  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface rv151_rgf_byp_if #(
  parameter int XLEN = rv151_pkg::XLEN_DEFAULT,
  parameter int AW   = 5
);

  logic            clr_req;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy;

  modport master (
    output clr_req, we, wa, wd, ra1, ra2,
    input  rd1, rd2, busy
  );

  modport slave (
    input  clr_req, we, wa, wd, ra1, ra2,
    output rd1, rd2, busy
  );

endinterface

`default_nettype wire

// File: rtl/rv151_rgf_clr.sv
// +------------------------------------------------------------------+
// | rv151_rgf_clr : clear sequencer FSM, walks every entry to zero   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rv151_rgf_clr
  import rv151_pkg::*;
#(
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rgf_state_t    r_state;
  rgf_state_t    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  // Reset lands in CLEAR so the array is scrubbed without a direct reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RGF_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RGF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RGF_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      RGF_CLEAR: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == AW'(NREG - 1)) begin
          w_state_nxt = RGF_IDLE;
        end
      end
      default: begin
        w_state_nxt = RGF_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign busy     = (r_state == RGF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/rv151_rgf_byp.sv
// +------------------------------------------------------------------+
// | rv151_rgf_byp : 2R1W register file with write bypass and clear   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rv151_rgf_byp
  import rv151_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  rv151_rgf_byp_if.slave    bus
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_busy;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_zero_drop;
  logic            w_wr_user;

  rv151_rgf_clr #(
    .NREG (NREG)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A user write only takes effect (and only forwards) when it will really land.
  assign w_zero_drop = (ZERO_REG != 0) && (bus.wa == '0);
  assign w_wr_user   = bus.we && !w_busy && !bus.clr_req && !rst && !w_zero_drop;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_user) begin
      r_mem[bus.wa] <= bus.wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = r_mem[ra];
    if (w_busy) begin
      v = '0;
    end else if ((BYPASS != 0) && w_wr_user && (bus.wa == ra)) begin
      v = bus.wd;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    bus.rd1 = read_port(bus.ra1);
    bus.rd2 = read_port(bus.ra2);
  end

  assign bus.busy = w_busy;

endmodule

`default_nettype wire
